dmem_boot_ctrl: RTL

- Boot/load controller for the single-cycle RV32 system.
- Holds the CPU in reset, accepts a stream of 32-bit words from an external host over a valid/ready handshake, and writes them as sw-width stores into data memory at consecutive word addresses.
- On the last word, releases the CPU and hands the data-memory write port back to the core.
- Sits between host/testbench and the top-level data-memory mux; replaces ad-hoc external write muxing during reset.

---
 rtl/dmem_boot_ctrl.sv | 110 +++++++++++
 1 files changed

// File: rtl/dmem_boot_ctrl.sv
// rtl/dmem_boot_ctrl.sv - boot loader: streams host words into data memory, then releases the CPU
// Optional: define DMEM_BOOT_CSUM_EN to accumulate a running checksum of the loaded words.
module dmem_boot_ctrl #(
    parameter logic [31:0] ADDR_BASE = 32'h0000_0000,
    parameter int          NUM_WORDS = 64,
    parameter int          CNT_W     = 7
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             ld_valid,
    input  logic             ld_last,
    input  logic [31:0]      ld_data,
    output logic             ld_ready,
    output logic             cpu_reset,
    output logic             dmem_we,
    output logic [2:0]       dmem_store,
    output logic [31:0]      dmem_addr,
    output logic [31:0]      dmem_wdata,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] word_count,
    output logic [31:0]      csum
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_LOAD  = 2'd1;
    localparam logic [1:0] S_FLUSH = 2'd2;
    localparam logic [1:0] S_RUN   = 2'd3;

    logic [1:0] state;
    logic       accept;
    logic       startOk;
    logic       lastWord;

    // Start is only honoured when no load is in progress.
    assign accept   = (state == S_LOAD) && ld_valid && ld_ready;
    assign startOk  = start && ((state == S_IDLE) || (state == S_RUN));
    assign lastWord = ld_last || (word_count == CNT_W'(NUM_WORDS - 1));

    // Every store the controller issues is a full word.
    assign dmem_store = 3'b010;

    // Session FSM with registered outputs; the final write lands in the FLUSH cycle.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= S_IDLE;
            cpu_reset  <= 1'b1;
            ld_ready   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= ADDR_BASE;
            dmem_wdata <= 32'h0;
            word_count <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            dmem_we <= 1'b0;
            case (state)
                S_IDLE, S_RUN: begin
                    if (startOk) begin
                        state      <= S_LOAD;
                        ld_ready   <= 1'b1;
                        busy       <= 1'b1;
                        done       <= 1'b0;
                        cpu_reset  <= 1'b1;
                        word_count <= '0;
                    end
                end
                S_LOAD: begin
                    if (accept) begin
                        dmem_we    <= 1'b1;
                        dmem_addr  <= ADDR_BASE + (32'(word_count) << 2);
                        dmem_wdata <= ld_data;
                        word_count <= word_count + CNT_W'(1);
                        if (lastWord) begin
                            state    <= S_FLUSH;
                            ld_ready <= 1'b0;
                        end
                    end
                end
                default: begin
                    state     <= S_RUN;
                    busy      <= 1'b0;
                    done      <= 1'b1;
                    cpu_reset <= 1'b0;
                end
            endcase
        end
    end

`ifdef DMEM_BOOT_CSUM_EN
    logic [31:0] csumReg;

    // Checksum advances alongside word_count and restarts with each session.
    always_ff @(posedge clk) begin
        if (!reset) begin
            csumReg <= 32'h0;
        end else if (startOk) begin
            csumReg <= 32'h0;
        end else if (accept) begin
            csumReg <= csumReg + ld_data;
        end
    end

    assign csum = csumReg;
`else
    assign csum = 32'h0;
`endif

endmodule
